// File: rtl/q_max_scanner.sv
// q_max_scanner: scans nine Q-table entries, returns best free cell and max Q.
// Optional epsilon-greedy exploration via `define Q_EPSILON_EXPLORE_EN.
module q_max_scanner #(
  parameter int Q_W     = 8,
  parameter int N_CELLS = 9,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_CELLS-1:0] occupied,
`ifdef Q_EPSILON_EXPLORE_EN
  input  logic [7:0]         epsilon,
  output logic               explored,
`endif
  output logic               q_rd_en,
  output logic [ADDR_W-1:0]  q_rd_addr,
  input  logic [Q_W-1:0]     q_rd_data,
  output logic               busy,
  output logic               done,
  output logic [Q_W-1:0]     max_Q,
  output logic [ADDR_W-1:0]  best_action,
  output logic               no_move
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr;
  logic [N_CELLS-1:0]  mask_r;
  logic [Q_W-1:0]      acc_max, acc_max_n;
  logic [ADDR_W-1:0]   acc_idx, acc_idx_n;
  logic                found, found_n;
  logic                prev_en;
  logic [ADDR_W-1:0]   prev_addr;
  logic [ADDR_W-1:0]   sel_idx;
  logic                scan;
  logic                last;
  logic                take;

  assign scan      = (state == SCAN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign last      = (addr == ADDR_W'(N_CELLS - 1));
  assign take      = (state == IDLE) && start;
  assign q_rd_en   = scan && !mask_r[addr];
  assign q_rd_addr = scan ? addr : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SCAN;
      SCAN:    if (last) state_n = DRAIN;
      DRAIN:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Compare stage on the read issued one cycle earlier
  always_comb begin
    acc_max_n = acc_max;
    acc_idx_n = acc_idx;
    found_n   = found;
    if (prev_en && (!found || (q_rd_data > acc_max))) begin
      acc_max_n = q_rd_data;
      acc_idx_n = prev_addr;
      found_n   = 1'b1;
    end
  end

  // Scan address, latched mask, accumulators and read pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      mask_r    <= '0;
      acc_max   <= '0;
      acc_idx   <= '0;
      found     <= 1'b0;
      prev_en   <= 1'b0;
      prev_addr <= '0;
    end else begin
      prev_en   <= q_rd_en;
      prev_addr <= addr;
      if (take) begin
        mask_r  <= occupied;
        addr    <= '0;
        acc_max <= '0;
        acc_idx <= '0;
        found   <= 1'b0;
      end else begin
        acc_max <= acc_max_n;
        acc_idx <= acc_idx_n;
        found   <= found_n;
        if (scan && !last) addr <= addr + 1'b1;
      end
    end
  end

`ifdef Q_EPSILON_EXPLORE_EN
  logic [7:0]        lfsr;
  logic [3:0]        lfsr_lo;
  logic [ADDR_W-1:0] rnd_n, rnd_r;
  logic              explore_r;
  logic [ADDR_W-1:0] lo_idx, hi_idx;
  logic              hi_v;

  assign lfsr_lo = lfsr[3:0];
  assign rnd_n   = (lfsr_lo >= 4'(N_CELLS))
                 ? ADDR_W'(lfsr_lo - 4'(N_CELLS))
                 : ADDR_W'(lfsr_lo);

  // Free-running x^8+x^6+x^5+x^4+1 LFSR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'h01;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Capture the explore decision and random start cell at request time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      explore_r <= 1'b0;
      rnd_r     <= '0;
    end else if (take) begin
      explore_r <= (lfsr < epsilon);
      rnd_r     <= rnd_n;
    end
  end

  // First free cell at or above rnd, else the lowest free cell
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_v   = 1'b0;
    for (int i = N_CELLS - 1; i >= 0; i--) begin
      if (!mask_r[i]) begin
        lo_idx = ADDR_W'(i);
        if (ADDR_W'(i) >= rnd_r) begin
          hi_idx = ADDR_W'(i);
          hi_v   = 1'b1;
        end
      end
    end
  end

  assign sel_idx = (explore_r && found_n)
                 ? (hi_v ? hi_idx : lo_idx)
                 : acc_idx_n;

  // Exploration flag, updated with the results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              explored <= 1'b0;
    else if (state == DRAIN) explored <= explore_r && found_n;
  end
`else
  assign sel_idx = acc_idx_n;
`endif

  // Result registers, loaded entering DONE and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_Q       <= '0;
      best_action <= '0;
      no_move     <= 1'b0;
    end else if (state == DRAIN) begin
      max_Q       <= acc_max_n;
      best_action <= sel_idx;
      no_move     <= !found_n;
    end
  end

endmodule

// File: tb/tb_q_max_scanner.sv
// tb_q_max_scanner: directed tests for q_max_scanner (greedy build).
// Q table modelled as a synchronous-read memory.
module tb_q_max_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] occupied = '0;
  logic [7:0] q_rd_data = '0;
  logic       q_rd_en;
  logic [3:0] q_rd_addr;
  logic       busy;
  logic       done;
  logic [7:0] max_Q;
  logic [3:0] best_action;
  logic       no_move;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int bad_cnt = 0;
  int done_cnt = 0;
  logic [8:0] occ_ref = '0;
  logic [7:0] q_mem [16];

  localparam logic [71:0] SET1 =
    {8'd5, 8'd8, 8'd4, 8'd0, 8'd1, 8'd9, 8'd2, 8'd7, 8'd3};
  localparam logic [71:0] ALL6 = {9{8'd6}};

  q_max_scanner dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .occupied(occupied),
    .q_rd_en(q_rd_en),
    .q_rd_addr(q_rd_addr),
    .q_rd_data(q_rd_data),
    .busy(busy),
    .done(done),
    .max_Q(max_Q),
    .best_action(best_action),
    .no_move(no_move)
  );

  always #5 clk = ~clk;

  // Synchronous Q-table read and read/done monitors
  always @(posedge clk) begin
    if (q_rd_en) begin
      q_rd_data <= q_mem[q_rd_addr];
      rd_cnt = rd_cnt + 1;
      if (q_rd_addr > 4'd8 || occ_ref[q_rd_addr]) bad_cnt = bad_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic load_q(input logic [71:0] v);
    for (int i = 0; i < 16; i++) q_mem[i] = 8'hEE;
    for (int i = 0; i < 9; i++) q_mem[i] = v[8*i +: 8];
  endtask

  task automatic scan(input string nm, input logic [8:0] occ,
                      input logic [8:0] occ_late, input logic [7:0] emax,
                      input logic [3:0] eidx, input logic enm,
                      input int ereads);
    int r0, b0, cyc;
    logic got;
    occ_ref = occ;
    r0 = rd_cnt;
    b0 = bad_cnt;
    got = 1'b0;
    cyc = 0;
    @(posedge clk); #1;
    start = 1'b1;
    occupied = occ;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0;
        occupied = occ_late;
      end
      @(negedge clk);
      cyc = c;
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy: got %b want 1", nm, busy);
        end
      end
      if (done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || cyc != 11) begin
      errors++;
      $display("FAIL %s latency: got %0d (done seen %b) want 11", nm, cyc, got);
    end
    checks++;
    if (max_Q !== emax) begin
      errors++;
      $display("FAIL %s max_Q: got %0d want %0d", nm, max_Q, emax);
    end
    checks++;
    if (best_action !== eidx) begin
      errors++;
      $display("FAIL %s best_action: got %0d want %0d", nm, best_action, eidx);
    end
    checks++;
    if (no_move !== enm) begin
      errors++;
      $display("FAIL %s no_move: got %b want %b", nm, no_move, enm);
    end
    checks++;
    if (rd_cnt - r0 != ereads) begin
      errors++;
      $display("FAIL %s reads: got %0d want %0d", nm, rd_cnt - r0, ereads);
    end
    checks++;
    if (bad_cnt != b0) begin
      errors++;
      $display("FAIL %s occupied_read: got %0d want 0", nm, bad_cnt - b0);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if ({q_rd_en, q_rd_addr, busy, done, max_Q, best_action, no_move}
        !== 19'd0) begin
      errors++;
      $display("FAIL %s reset_vals: got en=%b addr=%0d busy=%b done=%b max=%0d idx=%0d nm=%b want all 0",
               nm, q_rd_en, q_rd_addr, busy, done, max_Q, best_action, no_move);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_greedy;
    load_q(SET1);
    scan("free_all", 9'h000, 9'h000, 8'd9, 4'd3, 1'b0, 9);
    scan("cell3_taken", 9'h008, 9'h000, 8'd8, 4'd7, 1'b0, 8);
    load_q(ALL6);
    scan("tie_low", 9'h003, 9'h003, 8'd6, 4'd2, 1'b0, 7);
    load_q(SET1);
    scan("zero_q_only", 9'h1DF, 9'h1DF, 8'd0, 4'd5, 1'b0, 1);
  endtask

  task automatic test_no_move;
    load_q(SET1);
    scan("full_board", 9'h1FF, 9'h000, 8'd0, 4'd0, 1'b1, 0);
  endtask

  task automatic test_back_to_back;
    load_q(SET1);
    scan("b2b_first", 9'h000, 9'h000, 8'd9, 4'd3, 1'b0, 9);
    scan("b2b_second", 9'h1FF, 9'h1FF, 8'd0, 4'd0, 1'b1, 0);
  endtask

  task automatic test_hold_and_done_start;
    load_q(SET1);
    scan("hold_first", 9'h000, 9'h000, 8'd9, 4'd3, 1'b0, 9);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: got busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clk); #1;
    start = 1'b1;
    occupied = 9'h008;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (max_Q !== 8'd9 || best_action !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_mid_scan: got max=%0d idx=%0d busy=%b want 9 3 1",
               max_Q, best_action, busy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (max_Q !== 8'd8 || best_action !== 4'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_second: got max=%0d idx=%0d busy=%b want 8 7 0",
               max_Q, best_action, busy);
    end
  endtask

  task automatic test_reset_mid_scan;
    int r0, d0;
    load_q(SET1);
    occ_ref = 9'h000;
    @(posedge clk); #1;
    start = 1'b1;
    occupied = 9'h000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || q_rd_addr !== 4'd4) begin
      errors++;
      $display("FAIL restart_ignored: got busy=%b addr=%0d want 1 4", busy, q_rd_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_scan_reset");
    r0 = rd_cnt;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (rd_cnt != r0 || done_cnt != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_quiet: got reads=%0d dones=%0d busy=%b want 0 0 0",
               rd_cnt - r0, done_cnt - d0, busy);
    end
    scan("fresh_after_reset", 9'h000, 9'h000, 8'd9, 4'd3, 1'b0, 9);
  endtask

  initial begin
    test_reset();
    test_greedy();
    test_no_move();
    test_back_to_back();
    test_hold_and_done_start();
    test_reset_mid_scan();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
